wb_cmd_master: RTL
==================

# wb_cmd_master

Wishbone B4 classic single-transfer master that is the initiator end of the user-area Wishbone slave bus. It accepts one read or write command over a valid/ready interface, runs exactly one Wishbone cycle to a slave such as the mixer register block, and returns the read data or an error over a valid/ready response channel. It enables on-chip or test-harness access to user slaves without the management SoC.

## Interface
- TIMEOUT_CYCLES, 255: maximum number of BUS-state cycles to wait for `wbm_ack_i`; legal range 1..65535.
- wb_clk_i  input  1  bus clock; all logic is on the rising edge.
- wb_rst_ni  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  master can accept a command.
- cmd_we_i  input  1  1 = write, 0 = read.
- cmd_adr_i  input  32  byte address.
- cmd_dat_i  input  32  write data.
- cmd_sel_i  input  4  byte lanes.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  consumer takes the response.
- rsp_dat_o  output  32  read data; 0 for writes and errors.
- rsp_err_o  output  1  transfer timed out.
- wbm_cyc_o, wbm_stb_o  output  1 each  Wishbone cycle and strobe.
- wbm_we_o  output  1  Wishbone write enable.
- wbm_sel_o  output  4  Wishbone byte select.
- wbm_adr_o  output  32  Wishbone address.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_ack_i  input  1  slave acknowledge.
- wbm_dat_i  input  32  slave read data.

## Operation
- FSM states: IDLE, BUS, RESP. Reset enters IDLE.
- IDLE: `cmd_ready_o`=1. When `cmd_valid_i` is 1, the block latches we, adr, dat, and sel into the wbm_* registers, sets cyc and stb to 1, clears the timeout counter, and goes to BUS.
- BUS: cyc, stb, and all wbm_* outputs are held stable. `cmd_ready_o`=0.
  - On `wbm_ack_i`=1: cyc and stb drop to 0. `rsp_dat_o` is set to `wbm_dat_i` for a read and to 0 for a write. `rsp_err_o`=0. The FSM goes to RESP.
  - Each cycle without an ack increments the counter.
- RESP: `rsp_valid_o`=1, and rsp_dat and rsp_err are held. When `rsp_ready_i` is 1, the FSM goes to IDLE.
- The master accepts no new command until the response has been consumed. Exactly one transfer is outstanding at any time.
- `wbm_ack_i` is ignored in IDLE and RESP.
- The counter width is $clog2(TIMEOUT_CYCLES+1) bits. It saturates and does not wrap.

## Timing
- Reset values: cmd_ready_o=0 while reset is asserted and 1 after release; rsp_valid_o, rsp_err_o, wbm_cyc_o, wbm_stb_o, and wbm_we_o are 0; all data, address, and sel outputs are 0.
- Reset asserted mid-transfer clears cyc and stb immediately (asynchronously). The abandoned transfer produces no response.
- Command accepted at edge N: cyc and stb are 1 from N until the edge at which ack is sampled.
- Ack sampled at edge M: cyc and stb are 0 and rsp_valid_o is 1 from M.
- Minimum command-to-response latency is 2 edges, which occurs when the slave returns ack combinationally.
- Response consumed at edge K: cmd_ready_o is 1 from K. The next command can be accepted at edge K+1.
- Wishbone rules: stb is only ever high when cyc is high. Outputs do not change while stb=1 and ack=0.

## Configuration
- `WBM_TIMEOUT_EN` defined:
  - When the counter reaches TIMEOUT_CYCLES in BUS without an ack, cyc and stb drop at the next edge, the FSM enters RESP, `rsp_err_o`=1, and `rsp_dat_o`=0.
  - If ack and timeout occur in the same cycle, the ack wins and the transfer completes normally.
- Not defined: no counter logic is built. `rsp_err_o` is tied to 0, and BUS waits indefinitely for an ack.

## Test plan
- Write 0xDEADBEEF to address 0x3000_0004 with sel=0xF against a slave that acks one cycle late: the Wishbone outputs show the exact values, cyc and stb are high for 2 cycles, then rsp_valid=1, rsp_dat=0, and rsp_err=0.
- Read address 0x3000_0000 with the slave returning 0x1234_5678 and a combinational ack: rsp_dat=0x12345678, 2 edges after the command.
- Hold rsp_ready_i=0 for 10 cycles while cmd_valid_i=1: cmd_ready_o stays 0, no second cycle starts, and the response is stable throughout.
- `WBM_TIMEOUT_EN` with TIMEOUT_CYCLES=4 and a slave that never acks:
  - cyc drops after 4 BUS cycles, with rsp_err=1 and rsp_dat=0.
  - An ack arriving on the timeout cycle instead gives rsp_err=0.
- Assert wb_rst_ni low in the middle of BUS:
  - cyc and stb go to 0 asynchronously, and no rsp_valid is produced.
  - After release, cmd_ready_o=1 and a subsequent read completes normally.
- 100 back-to-back random reads and writes with random slave wait states (0..7): every response matches a reference model, and stb is never high while cyc is low.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic single-transfer master driven by a valid/ready command channel.
// Optional bus timeout is built only when WBM_TIMEOUT_EN is defined.
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;

`ifdef WBM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            rsp_dat_q <= '0;
`ifdef WBM_TIMEOUT_EN
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            rsp_dat_q <= rsp_dat_d;
`ifdef WBM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        rsp_dat_d = rsp_dat_q;
`ifdef WBM_TIMEOUT_EN
        cnt_d     = cnt_q;
        rsp_err_d = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
`ifdef WBM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
`ifdef WBM_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                    state_d   = RESP;
                end
`ifdef WBM_TIMEOUT_EN
                // The counter reaches TIMEOUT_CYCLES at this edge, so give up now.
                else if (cnt_q == CNT_LAST) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    rsp_dat_d = 32'h0;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready_o = wb_rst_ni && (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_dat_o   = rsp_dat_q;
`ifdef WBM_TIMEOUT_EN
    assign rsp_err_o   = rsp_err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule
